seq_alu: RTL and testbench

Parametrised, registered ALU with a start/done handshake: single-cycle logic and shift operations plus iterative unsigned multiply and divide. It is the execute-stage arithmetic unit for the multi-cycle CPU. It replaces the purely combinational ALU and adds a HI result register for 2×WIDTH products and remainders.

---
 rtl/seq_alu.sv | 180 ++++++++++++++++++
 tb/tb_seq_alu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle logic/shift ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), with start/done handshake.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI,
    output logic             dz
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] CNT_INIT = (SW+1)'(WIDTH);
    localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SRL  = 4'd4,
        OP_SRA  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SLT  = 4'd7,
        OP_MULU = 4'd8,
        OP_DIVU = 4'd9
    } op_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend->quotient
    logic [SW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] single_c_s;
    logic [SW-1:0]    shamt_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s, mul_lo_s;
    logic [WIDTH:0]   div_shift_s, div_diff_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_hi_s, div_lo_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;

    // Single-cycle operation result
    always_comb begin
        single_c_s = '0;
        shamt_s    = B[SW-1:0];
        case (ALUOp)
            OP_ADD:  single_c_s = A + B;
            OP_SUB:  single_c_s = A - B;
            OP_AND:  single_c_s = A & B;
            OP_OR:   single_c_s = A | B;
            OP_SRL:  single_c_s = A >> shamt_s;
            OP_SRA:  single_c_s = $unsigned($signed(A) >>> shamt_s);
            OP_SLL:  single_c_s = A << shamt_s;
            OP_SLT:  single_c_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: single_c_s = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_hi_s    = mul_sum_s[WIDTH:1];
        mul_lo_s    = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
        div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
        div_hi_s    = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
        div_lo_s    = {acc_lo_q[WIDTH-2:0], div_ge_s};
        if (is_div_q) begin
            step_hi_s = div_hi_s;
            step_lo_s = div_lo_s;
        end else begin
            step_hi_s = mul_hi_s;
            step_lo_s = mul_lo_s;
        end
    end

    // Next-state and result-register logic
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        hi_d     = hi_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((ALUOp == OP_MULU) || (ALUOp == OP_DIVU)) begin
                        state_d  = RUN;
                        is_div_d = (ALUOp == OP_DIVU);
                        opnd_d   = (ALUOp == OP_DIVU) ? B : A;
                        acc_lo_d = (ALUOp == OP_DIVU) ? A : B;
                        acc_hi_d = '0;
                        cnt_d    = CNT_INIT;
                    end else begin
                        c_d    = single_c_s;
                        hi_d   = '0;
                        dz_d   = 1'b0;
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_hi_d = step_hi_s;
                acc_lo_d = step_lo_s;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    c_d     = step_lo_s;
                    hi_d    = step_hi_s;
                    dz_d    = is_div_q && (opnd_q == '0);
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            c_q      <= '0;
            hi_q     <= '0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            hi_q     <= hi_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign C    = c_q;
    assign HI   = hi_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven self-checking bench for seq_alu (WIDTH=32 and WIDTH=8).
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dz;
    logic [31:0] c, hi;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  c8, hi8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } vec_t;

    vec_t vecs[13];

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(op), .A(a), .B(b),
        .busy(busy), .done(done), .C(c), .HI(hi), .dz(dz)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ALUOp(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .C(c8), .HI(hi8), .dz(dz8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a mulu/divu, track busy for 32 cycles, check the done cycle and the one after
    task automatic run_long(input string name, input logic [3:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ec, input logic [31:0] eh,
                            input logic edz, input bit inject);
        logic ok;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
            if (inject && k >= 2 && k <= 30) begin
                start = 1'b1; op = 4'd0; a = 32'd1000 + 32'(k); b = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check({name, "_busy_window"}, {63'd0, ok}, 64'd1);
        check({name, "_done"}, {63'd0, done}, 64'd1);
        check({name, "_busy_off"}, {63'd0, busy}, 64'd0);
        check({name, "_C"}, {32'd0, c}, {32'd0, ec});
        check({name, "_HI"}, {32'd0, hi}, {32'd0, eh});
        check({name, "_dz"}, {63'd0, dz}, {63'd0, edz});
        tick();
        check({name, "_done_once"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{"add_wrap",  4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[1]  = '{"sub_wrap",  4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[2]  = '{"and",       4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        vecs[3]  = '{"or",        4'd3, 32'h12340000, 32'h00005678, 32'h12345678};
        vecs[4]  = '{"sra",       4'd5, 32'h80000000, 32'd36,       32'hF8000000};
        vecs[5]  = '{"srl",       4'd4, 32'h80000000, 32'd36,       32'h08000000};
        vecs[6]  = '{"sll",       4'd6, 32'h00000001, 32'd31,       32'h80000000};
        vecs[7]  = '{"slt_neg",   4'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[8]  = '{"slt_pos",   4'd7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{"slt_eq",    4'd7, 32'h00000005, 32'h00000005, 32'h00000000};
        vecs[10] = '{"reserved",  4'd12, 32'h00000005, 32'h00000003, 32'h00000000};
        vecs[11] = '{"add",       4'd0, 32'h00000007, 32'h00000008, 32'h0000000F};
        vecs[12] = '{"sub_neg",   4'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE};

        rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
        start8 = 1'b0; op8 = 4'd0; a8 = '0; b8 = '0;
        tick();
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_C", {32'd0, c}, 64'd0);
        check("rst_HI", {32'd0, hi}, 64'd0);
        check("rst_dz", {63'd0, dz}, 64'd0);
        check("rst8_C", {56'd0, c8}, 64'd0);
        rst_n = 1'b1;

        // Back-to-back single-cycle ops, start high every cycle
        for (int i = 0; i < 13; i++) begin
            start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            tick();
            check({vecs[i].name, "_done"}, {63'd0, done}, 64'd1);
            check({vecs[i].name, "_busy"}, {63'd0, busy}, 64'd0);
            check({vecs[i].name, "_C"}, {32'd0, c}, {32'd0, vecs[i].c});
            check({vecs[i].name, "_HI"}, {32'd0, hi}, 64'd0);
        end
        start = 1'b0;
        tick();
        check("single_done_drop", {63'd0, done}, 64'd0);
        check("single_C_hold", {32'd0, c}, {32'd0, 32'hFFFFFFFE});

        run_long("mulu_max", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_long("mulu_2^32", 4'd8, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
        run_long("divu_100_7", 4'd9, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        run_long("divu_by0", 4'd9, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0);
        check("dz_hold", {63'd0, dz}, 64'd1);

        start = 1'b1; op = 4'd0; a = 32'd2; b = 32'd3;
        tick();
        start = 1'b0;
        check("add_clr_dz", {63'd0, dz}, 64'd0);
        check("add_clr_C", {32'd0, c}, 64'd5);
        check("add_clr_HI", {32'd0, hi}, 64'd0);

        run_long("divu_big", 4'd9, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0);
        run_long("mulu_ignore", 4'd8, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 1'b1);

        // Abort a multiply with reset in RUN cycle 10
        start = 1'b1; op = 4'd8; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_C", {32'd0, c}, 64'd0);
        check("abort_HI", {32'd0, hi}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
                tick();
            end
            check("abort_no_done", {63'd0, seen}, 64'd0);
        end

        // WIDTH=8 instance
        start8 = 1'b1; op8 = 4'd8; a8 = 8'hFF; b8 = 8'h02;
        tick();
        start8 = 1'b0;
        begin
            logic ok8;
            ok8 = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                if (busy8 !== 1'b1 || done8 !== 1'b0) ok8 = 1'b0;
                tick();
            end
            check("w8_mulu_busy", {63'd0, ok8}, 64'd1);
        end
        check("w8_mulu_done", {63'd0, done8}, 64'd1);
        check("w8_mulu_C", {56'd0, c8}, 64'hFE);
        check("w8_mulu_HI", {56'd0, hi8}, 64'h01);

        start8 = 1'b1; op8 = 4'd6; a8 = 8'h01; b8 = 8'h0B;
        tick();
        start8 = 1'b0;
        check("w8_sll_done", {63'd0, done8}, 64'd1);
        check("w8_sll_C", {56'd0, c8}, 64'h08);
        check("w8_sll_HI", {56'd0, hi8}, 64'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
